id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and EX-stage operand selector of the 5-stage RV32I core.
- Captures decoded fields from ID every cycle. Consumes the hazard unit's forward flags and stop_ID, and inserts a bubble on a load-use stall.
- Supplies the ALU with forwarded operands, taken from the MEM- or WB-stage result.
- Downstream neighbour of the hazard unit; upstream of the ALU and the EX/MEM register.

Parameters:
- XLEN, 32, datapath width
- ALU_OP_W, 4, width of the ALU operation code
- CNT_W, 16, width of the stall/flush performance counters

Ports:
- clk  in  1  clock; all state updates on posedge clk
- reset  in  1  synchronous, active-high reset
- valid_ID  in  1  ID holds a real instruction
- pc_ID  in  XLEN  PC of the ID instruction
- rs1_data_ID  in  XLEN  register-file read data for rs1
- rs2_data_ID  in  XLEN  register-file read data for rs2
- imm_ID  in  XLEN  sign-extended immediate
- rd_ID  in  5  destination register
- alu_op_ID  in  ALU_OP_W  ALU operation code
- alu_src_imm_ID  in  1  operand B is the immediate
- is_load_ID, is_store_ID, reg_write_ID  in  1 each  control bits
- forward_EX_A, forward_EX_B  in  1 each  hazard-unit flags: producer will be in MEM when this instruction is in EX
- forward_MEM_A, forward_MEM_B  in  1 each  hazard-unit flags: producer will be in WB
- stop_ID  in  1  load-use stall request from the hazard unit
- flush_EX  in  1  branch redirect; kill the instruction entering EX
- hold_EX  in  1  back-end freeze (memory busy); freezes EX, MEM and WB
- result_MEM  in  XLEN  ALU result currently in the MEM stage
- result_WB  in  XLEN  write-back value currently in the WB stage
- valid_EX  out  1  EX slot holds a real instruction
- pc_EX  out  XLEN  PC of the EX instruction
- operand_a_EX  out  XLEN  ALU operand A, after forwarding
- operand_b_EX  out  XLEN  ALU operand B, after forwarding and immediate select
- store_data_EX  out  XLEN  forwarded rs2 value
- rd_EX  out  5  destination register
- alu_op_EX  out  ALU_OP_W  ALU operation code
- is_load_EX, is_store_EX, reg_write_EX  out  1 each  control bits; is_load_EX feeds the hazard unit
- stall_count  out  CNT_W  number of bubbles inserted
- flush_count  out  CNT_W  number of valid instructions killed

Behaviour:
- Reset (synchronous):
  - Every registered field is cleared to 0, so all outputs are 0.
  - Counters are cleared to 0.
  - Reset overrides every other input in the same cycle.
- Posedge update priority: reset > hold_EX > flush_EX > stop_ID > normal load.
  - hold_EX: all registers keep their value, including the latched forward flags. Counters do not change.
  - flush_EX: insert a bubble. flush_count increments if valid_ID=1.
  - stop_ID: insert a bubble. stall_count increments.
  - Normal: latch every *_ID field, rs1_data, rs2_data and the four forward flags.
- Bubble definition:
  - valid, reg_write, is_load and is_store are 0, and rd=0.
  - Forward flags are 0.
  - Data fields are don't-care, but are driven to 0.
- flush_EX and stop_ID in the same cycle: flush only; flush_count increments (if valid_ID=1), stall_count does not.
- Operand A (combinational, 0-cycle latency from latched state):
  - latched fwdEX_A → result_MEM
  - else latched fwdMEM_A → result_WB
  - else latched rs1_data
  - fwdEX has priority if both flags are set.
- Forwarded B: same rule with the B flags and rs2_data.
- store_data_EX = forwarded B.
- operand_b_EX = imm when alu_src_imm is latched, else forwarded B.
- Load-use: the hazard unit holds ID for one cycle. The bubble fills the slot, and on the next load the forward_MEM flag routes result_WB (the load data).
- Counters saturate at all-ones; no wrap-around.
- A bubble never produces reg_write_EX=1 or is_load_EX=1, so it cannot cause a spurious hazard-unit stall.

Decomposition:
- Shared package core_pkg:
  - XLEN
  - ALU opcode localparams
  - the bubble field values
- One sub-module, operand_fwd_mux: the 3:1 priority mux, instantiated twice (A and B).
- Counters stay inline.

Test Plan:
- Reset: drive reset=1 for 2 cycles with valid_ID=1 and reg_write_ID=1 → all outputs 0 and both counters 0 after the first edge.
- Forwarding: latch rs1_data=0x11 with forward_EX_A=1, while result_MEM=0xAA and result_WB=0xBB → operand_a_EX=0xAA. With forward_MEM_A instead → 0xBB. With both flags → 0xAA.
- Load-use: stop_ID=1 for one cycle → the next EX slot has valid_EX=0, is_load_EX=0, rd_EX=0, and stall_count goes 0→1. The following instruction, latched with forward_MEM_B=1 and alu_src_imm=0, sees operand_b_EX=result_WB=0x1234.
- Flush vs stall: flush_EX=1, stop_ID=1, valid_ID=1 → bubble; flush_count=1, stall_count unchanged.
- Hold: hold_EX=1 for 3 cycles while ID inputs change → all EX outputs are stable and counters are unchanged. After release, the next edge latches the current ID inputs.
- Saturation: with CNT_W=4, issue 20 stop_ID cycles → stall_count stops at 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline: datapath width, ALU opcodes and
// the field values that make up an ID/EX pipeline bubble.
package core_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

  // A bubble must never look like a producer or a load to the hazard unit.
  localparam logic       BUBBLE_VALID     = 1'b0;
  localparam logic       BUBBLE_REG_WRITE = 1'b0;
  localparam logic       BUBBLE_IS_LOAD   = 1'b0;
  localparam logic       BUBBLE_IS_STORE  = 1'b0;
  localparam logic       BUBBLE_FWD       = 1'b0;
  localparam logic [4:0] BUBBLE_RD        = 5'd0;

endpackage

// File: rtl/operand_fwd_mux.sv
// 3:1 priority forwarding mux: MEM-stage result beats WB-stage result, which
// beats the register-file value latched in ID/EX.
module operand_fwd_mux #(
  parameter int W = 32
) (
  input  logic         fwd_mem,
  input  logic         fwd_wb,
  input  logic [W-1:0] reg_data,
  input  logic [W-1:0] result_mem,
  input  logic [W-1:0] result_wb,
  output logic [W-1:0] operand
);

  // Select the youngest available producer of the operand.
  always_comb begin
    operand = reg_data;
    if (fwd_mem) begin
      operand = result_mem;
    end else if (fwd_wb) begin
      operand = result_wb;
    end else begin
      operand = reg_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion on flush/load-use stall, plus
// the EX-stage operand forwarding and immediate selection feeding the ALU.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int ALU_OP_W = core_pkg::ALU_OP_W,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_ID,
  input  logic [XLEN-1:0]     pc_ID,
  input  logic [XLEN-1:0]     rs1_data_ID,
  input  logic [XLEN-1:0]     rs2_data_ID,
  input  logic [XLEN-1:0]     imm_ID,
  input  logic [4:0]          rd_ID,
  input  logic [ALU_OP_W-1:0] alu_op_ID,
  input  logic                alu_src_imm_ID,
  input  logic                is_load_ID,
  input  logic                is_store_ID,
  input  logic                reg_write_ID,
  input  logic                forward_EX_A,
  input  logic                forward_EX_B,
  input  logic                forward_MEM_A,
  input  logic                forward_MEM_B,
  input  logic                stop_ID,
  input  logic                flush_EX,
  input  logic                hold_EX,
  input  logic [XLEN-1:0]     result_MEM,
  input  logic [XLEN-1:0]     result_WB,
  output logic                valid_EX,
  output logic [XLEN-1:0]     pc_EX,
  output logic [XLEN-1:0]     operand_a_EX,
  output logic [XLEN-1:0]     operand_b_EX,
  output logic [XLEN-1:0]     store_data_EX,
  output logic [4:0]          rd_EX,
  output logic [ALU_OP_W-1:0] alu_op_EX,
  output logic                is_load_EX,
  output logic                is_store_EX,
  output logic                reg_write_EX,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                valid_r;
  logic [XLEN-1:0]     pc_r;
  logic [XLEN-1:0]     rs1_r;
  logic [XLEN-1:0]     rs2_r;
  logic [XLEN-1:0]     imm_r;
  logic [4:0]          rd_r;
  logic [ALU_OP_W-1:0] alu_op_r;
  logic                alu_src_imm_r;
  logic                is_load_r;
  logic                is_store_r;
  logic                reg_write_r;
  logic                fwd_ex_a_r;
  logic                fwd_ex_b_r;
  logic                fwd_mem_a_r;
  logic                fwd_mem_b_r;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic [CNT_W-1:0]    flush_cnt_r;
  logic [XLEN-1:0]     fwd_b_s;

  // Pipeline register: reset > hold > flush > stall > normal capture.
  always_ff @(posedge clk) begin
    if (reset || (!hold_EX && (flush_EX || stop_ID))) begin
      valid_r       <= BUBBLE_VALID;
      pc_r          <= {XLEN{1'b0}};
      rs1_r         <= {XLEN{1'b0}};
      rs2_r         <= {XLEN{1'b0}};
      imm_r         <= {XLEN{1'b0}};
      rd_r          <= BUBBLE_RD;
      alu_op_r      <= {ALU_OP_W{1'b0}};
      alu_src_imm_r <= 1'b0;
      is_load_r     <= BUBBLE_IS_LOAD;
      is_store_r    <= BUBBLE_IS_STORE;
      reg_write_r   <= BUBBLE_REG_WRITE;
      fwd_ex_a_r    <= BUBBLE_FWD;
      fwd_ex_b_r    <= BUBBLE_FWD;
      fwd_mem_a_r   <= BUBBLE_FWD;
      fwd_mem_b_r   <= BUBBLE_FWD;
    end else if (!hold_EX) begin
      valid_r       <= valid_ID;
      pc_r          <= pc_ID;
      rs1_r         <= rs1_data_ID;
      rs2_r         <= rs2_data_ID;
      imm_r         <= imm_ID;
      rd_r          <= rd_ID;
      alu_op_r      <= alu_op_ID;
      alu_src_imm_r <= alu_src_imm_ID;
      is_load_r     <= is_load_ID;
      is_store_r    <= is_store_ID;
      reg_write_r   <= reg_write_ID;
      fwd_ex_a_r    <= forward_EX_A;
      fwd_ex_b_r    <= forward_EX_B;
      fwd_mem_a_r   <= forward_MEM_A;
      fwd_mem_b_r   <= forward_MEM_B;
    end
  end

  // Saturating performance counters; a flush masks a simultaneous stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (hold_EX) begin
      stall_cnt_r <= stall_cnt_r;
      flush_cnt_r <= flush_cnt_r;
    end else if (flush_EX) begin
      if (valid_ID && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (stop_ID) begin
      if (stall_cnt_r != CNT_MAX) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  operand_fwd_mux #(.W(XLEN)) u_fwd_a (
    .fwd_mem    (fwd_ex_a_r),
    .fwd_wb     (fwd_mem_a_r),
    .reg_data   (rs1_r),
    .result_mem (result_MEM),
    .result_wb  (result_WB),
    .operand    (operand_a_EX)
  );

  operand_fwd_mux #(.W(XLEN)) u_fwd_b (
    .fwd_mem    (fwd_ex_b_r),
    .fwd_wb     (fwd_mem_b_r),
    .reg_data   (rs2_r),
    .result_mem (result_MEM),
    .result_wb  (result_WB),
    .operand    (fwd_b_s)
  );

  assign operand_b_EX  = alu_src_imm_r ? imm_r : fwd_b_s;
  assign store_data_EX = fwd_b_s;
  assign valid_EX      = valid_r;
  assign pc_EX         = pc_r;
  assign rd_EX         = rd_r;
  assign alu_op_EX     = alu_op_r;
  assign is_load_EX    = is_load_r;
  assign is_store_EX   = is_store_r;
  assign reg_write_EX  = reg_write_r;
  assign stall_count   = stall_cnt_r;
  assign flush_count   = flush_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; counters narrowed to 4 bits
// so saturation is reachable quickly.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int AW    = 4;
  localparam int CNT_W = 4;

  logic            clk;
  logic            reset;
  logic            valid_ID;
  logic [XLEN-1:0] pc_ID, rs1_data_ID, rs2_data_ID, imm_ID;
  logic [4:0]      rd_ID;
  logic [AW-1:0]   alu_op_ID;
  logic            alu_src_imm_ID, is_load_ID, is_store_ID, reg_write_ID;
  logic            forward_EX_A, forward_EX_B, forward_MEM_A, forward_MEM_B;
  logic            stop_ID, flush_EX, hold_EX;
  logic [XLEN-1:0] result_MEM, result_WB;
  logic            valid_EX;
  logic [XLEN-1:0] pc_EX, operand_a_EX, operand_b_EX, store_data_EX;
  logic [4:0]      rd_EX;
  logic [AW-1:0]   alu_op_EX;
  logic            is_load_EX, is_store_EX, reg_write_EX;
  logic [CNT_W-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(XLEN), .ALU_OP_W(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_ID(valid_ID), .pc_ID(pc_ID),
    .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID), .imm_ID(imm_ID),
    .rd_ID(rd_ID), .alu_op_ID(alu_op_ID), .alu_src_imm_ID(alu_src_imm_ID),
    .is_load_ID(is_load_ID), .is_store_ID(is_store_ID), .reg_write_ID(reg_write_ID),
    .forward_EX_A(forward_EX_A), .forward_EX_B(forward_EX_B),
    .forward_MEM_A(forward_MEM_A), .forward_MEM_B(forward_MEM_B),
    .stop_ID(stop_ID), .flush_EX(flush_EX), .hold_EX(hold_EX),
    .result_MEM(result_MEM), .result_WB(result_WB),
    .valid_EX(valid_EX), .pc_EX(pc_EX), .operand_a_EX(operand_a_EX),
    .operand_b_EX(operand_b_EX), .store_data_EX(store_data_EX), .rd_EX(rd_EX),
    .alu_op_EX(alu_op_EX), .is_load_EX(is_load_EX), .is_store_EX(is_store_EX),
    .reg_write_EX(reg_write_EX), .stall_count(stall_count), .flush_count(flush_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_id();
    valid_ID = 1'b0; pc_ID = 32'h0; rs1_data_ID = 32'h0; rs2_data_ID = 32'h0;
    imm_ID = 32'h0; rd_ID = 5'd0; alu_op_ID = 4'h0; alu_src_imm_ID = 1'b0;
    is_load_ID = 1'b0; is_store_ID = 1'b0; reg_write_ID = 1'b0;
    forward_EX_A = 1'b0; forward_EX_B = 1'b0; forward_MEM_A = 1'b0; forward_MEM_B = 1'b0;
    stop_ID = 1'b0; flush_EX = 1'b0; hold_EX = 1'b0;
  endtask

  // One posedge passes; outputs are then sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    clear_id();
    result_MEM = 32'hAA; result_WB = 32'hBB;
    valid_ID = 1'b1; reg_write_ID = 1'b1; is_load_ID = 1'b1; rd_ID = 5'd9;
    pc_ID = 32'h40; rs1_data_ID = 32'h11; rs2_data_ID = 32'h22;
    forward_EX_A = 1'b1; stop_ID = 1'b1; flush_EX = 1'b1;

    // Reset dominates every other input.
    tick();
    check("rst_valid", 32'(valid_EX), 32'h0);
    check("rst_regwr", 32'(reg_write_EX), 32'h0);
    check("rst_load", 32'(is_load_EX), 32'h0);
    check("rst_rd", 32'(rd_EX), 32'h0);
    check("rst_pc", pc_EX, 32'h0);
    check("rst_opa", operand_a_EX, 32'h0);
    check("rst_stall", 32'(stall_count), 32'h0);
    check("rst_flush", 32'(flush_count), 32'h0);
    tick();
    reset = 1'b0;

    // Forwarding priority on operand A.
    clear_id();
    valid_ID = 1'b1; pc_ID = 32'h100; rd_ID = 5'd3; reg_write_ID = 1'b1;
    alu_op_ID = 4'h2; rs1_data_ID = 32'h11; rs2_data_ID = 32'h22;
    forward_EX_A = 1'b1;
    tick();
    check("fwd_ex_a", operand_a_EX, 32'hAA);
    check("norm_valid", 32'(valid_EX), 32'h1);
    check("norm_pc", pc_EX, 32'h100);
    check("norm_rd", 32'(rd_EX), 32'h3);
    check("norm_aluop", 32'(alu_op_EX), 32'h2);
    check("norm_opb", operand_b_EX, 32'h22);
    forward_EX_A = 1'b0; forward_MEM_A = 1'b1;
    tick();
    check("fwd_mem_a", operand_a_EX, 32'hBB);
    forward_EX_A = 1'b1; forward_MEM_A = 1'b1;
    tick();
    check("fwd_both_a", operand_a_EX, 32'hAA);
    forward_EX_A = 1'b0; forward_MEM_A = 1'b0;
    alu_src_imm_ID = 1'b1; imm_ID = 32'h55; is_store_ID = 1'b1; forward_EX_B = 1'b1;
    tick();
    check("no_fwd_a", operand_a_EX, 32'h11);
    check("imm_opb", operand_b_EX, 32'h55);
    check("store_fwd", store_data_EX, 32'hAA);
    check("store_bit", 32'(is_store_EX), 32'h1);

    // Load-use: bubble, then WB forwarding of the load data.
    clear_id();
    valid_ID = 1'b1; is_load_ID = 1'b1; reg_write_ID = 1'b1; rd_ID = 5'd6;
    stop_ID = 1'b1;
    tick();
    check("lu_valid", 32'(valid_EX), 32'h0);
    check("lu_load", 32'(is_load_EX), 32'h0);
    check("lu_regwr", 32'(reg_write_EX), 32'h0);
    check("lu_rd", 32'(rd_EX), 32'h0);
    check("lu_stall", 32'(stall_count), 32'h1);
    clear_id();
    valid_ID = 1'b1; rd_ID = 5'd7; rs2_data_ID = 32'h99; forward_MEM_B = 1'b1;
    result_WB = 32'h1234;
    tick();
    check("lu_opb", operand_b_EX, 32'h1234);
    check("lu_store", store_data_EX, 32'h1234);
    check("lu_stall_hold", 32'(stall_count), 32'h1);

    // Flush wins over a simultaneous stall.
    clear_id();
    valid_ID = 1'b1; reg_write_ID = 1'b1; rd_ID = 5'd8; flush_EX = 1'b1; stop_ID = 1'b1;
    tick();
    check("fl_valid", 32'(valid_EX), 32'h0);
    check("fl_rd", 32'(rd_EX), 32'h0);
    check("fl_count", 32'(flush_count), 32'h1);
    check("fl_stall", 32'(stall_count), 32'h1);
    valid_ID = 1'b0; stop_ID = 1'b0;
    tick();
    check("fl_invalid", 32'(flush_count), 32'h1);

    // Hold freezes state and counters regardless of ID-side requests.
    clear_id();
    valid_ID = 1'b1; pc_ID = 32'h200; rd_ID = 5'd7; rs1_data_ID = 32'h77; reg_write_ID = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      hold_EX = 1'b1; pc_ID = 32'h300 + 32'(i); rd_ID = 5'(10 + i); rs1_data_ID = 32'h5;
      stop_ID = (i == 0); flush_EX = (i == 1); forward_EX_A = 1'b1;
      tick();
      check("hold_pc", pc_EX, 32'h200);
      check("hold_rd", 32'(rd_EX), 32'h7);
      check("hold_opa", operand_a_EX, 32'h77);
      check("hold_stall", 32'(stall_count), 32'h1);
      check("hold_flush", 32'(flush_count), 32'h1);
    end
    clear_id();
    valid_ID = 1'b1; pc_ID = 32'h400; rd_ID = 5'd12;
    tick();
    check("rel_pc", pc_EX, 32'h400);
    check("rel_rd", 32'(rd_EX), 32'hC);

    // Stall counter saturates at all-ones.
    stop_ID = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall", 32'(stall_count), 32'hF);
    check("sat_flush", 32'(flush_count), 32'h1);

    // Reset overrides hold.
    stop_ID = 1'b0; hold_EX = 1'b1; reset = 1'b1;
    tick();
    check("rst_hold_stall", 32'(stall_count), 32'h0);
    check("rst_hold_flush", 32'(flush_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
